// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: steps each instruction through INIT/IF/ID/EX/MEM/WB
// and drives the datapath selects combinationally from state, opcode and func.
module mc_ctrl #(
    parameter int unsigned ALUCTRL_W   = 5,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic [1:0]           PC_sel,
    output logic [1:0]           RegDst,
    output logic                 ALUSrc,
    output logic                 ExtOp,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           DatatoReg,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 bus_err
);

    localparam int unsigned CNT_W = 8;

    // ALU operation codes shared with the datapath ALU
    localparam logic [ALUCTRL_W-1:0] ALU_ADDU = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_SUBU = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_EQL  = ALUCTRL_W'(11);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic is_addu, is_subu, is_rtype, is_ori, is_beq, is_lw, is_sw, is_j, legal;
    logic mem_done, mem_tmo;

    // Instruction decode
    always_comb begin
        is_addu  = (opcode == OP_RTYPE) && (func == FN_ADDU);
        is_subu  = (opcode == OP_RTYPE) && (func == FN_SUBU);
        is_rtype = is_addu || is_subu;
        is_ori   = (opcode == OP_ORI);
        is_beq   = (opcode == OP_BEQ);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_j     = (opcode == OP_J);
        legal    = is_rtype || is_ori || is_beq || is_lw || is_sw || is_j;
    end

    assign mem_done = !MEM_WAIT_EN || mem_ready;
    assign mem_tmo  = (cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur <= S_INIT;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next state and datapath controls
    always_comb begin
        nxt       = S_INIT;
        cnt_nxt   = '0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PC_sel    = 2'b00;
        RegDst    = 2'b00;
        ALUSrc    = 1'b0;
        ExtOp     = 1'b0;
        ALUCtrl   = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        DatatoReg = 2'b00;
        illegal   = 1'b0;
        bus_err   = 1'b0;

        // ALU/RF selects are asserted in EX and held through WB
        if (cur == S_EX || cur == S_WB) begin
            if (is_rtype) begin
                RegDst  = 2'b01;
                ALUCtrl = is_addu ? ALU_ADDU : ALU_SUBU;
            end else if (is_ori) begin
                ALUSrc  = 1'b1;
                ALUCtrl = ALU_OR;
            end else if (is_lw || is_sw) begin
                ALUSrc  = 1'b1;
                ExtOp   = 1'b1;
                ALUCtrl = ALU_ADDU;
            end
        end

        case (cur)
            S_INIT: nxt = S_IF;
            S_IF: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                nxt     = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    PCWrite = 1'b1;
                    PC_sel  = 2'b10;
                    nxt     = S_IF;
                end else if (!legal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                if (is_beq) begin
                    ALUCtrl = ALU_EQL;
                    PCWrite = zero;
                    PC_sel  = 2'b01;
                    nxt     = S_IF;
                end else if (is_lw || is_sw) begin
                    nxt = S_MEM;
                end else if (is_rtype || is_ori) begin
                    nxt = S_WB;
                end else begin
                    nxt = S_IF;
                end
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                // A ready on the timeout cycle still counts as success
                if (mem_done) begin
                    nxt = is_lw ? S_WB : S_IF;
                end else if (mem_tmo) begin
                    bus_err = 1'b1;
                    nxt     = S_IF;
                end else begin
                    nxt     = S_MEM;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                DatatoReg = is_lw ? 2'b01 : 2'b00;
                nxt       = S_IF;
            end
            default: nxt = S_INIT;
        endcase
    end

    assign state = 3'(cur);

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction's per-cycle control vector is predicted
// from the instruction class, the zero flag and the number of memory wait cycles.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opcode, func;
    logic       zero, mem_ready;
    logic       IRWrite, PCWrite, ALUSrc, ExtOp, MemRead, MemWrite, RegWrite, illegal, bus_err;
    logic [1:0] PC_sel, RegDst, DatatoReg;
    logic [4:0] ALUCtrl;
    logic [2:0] state;

    mc_ctrl #(.ALUCTRL_W(5), .MEM_WAIT_EN(1'b1), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .PC_sel(PC_sel),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .DatatoReg(DatatoReg), .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw, pcw;
        logic [1:0] pcsel, regdst;
        logic       alusrc, extop;
        logic [4:0] aluctrl;
        logic       mrd, mwr, rwr;
        logic [1:0] dtr;
        logic [2:0] st;
        logic       ill, berr;
    } ov_t;

    ov_t  dut_v;
    ov_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign dut_v = {IRWrite, PCWrite, PC_sel, RegDst, ALUSrc, ExtOp, ALUCtrl,
                    MemRead, MemWrite, RegWrite, DatatoReg, state, illegal, bus_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) ||
               op == 6'h0d || op == 6'h04 || op == 6'h23 || op == 6'h2b || op == 6'h02;
    endfunction

    // Predict the cycle-by-cycle control vectors of one instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w);
        ov_t v, ex;
        bit  lw, sw, tmo;
        int  n;
        exp_q.delete();
        v = '0; v.irw = 1; v.pcw = 1; v.st = 3'd1;
        exp_q.push_back(v);
        v = '0; v.st = 3'd2;
        if (op == 6'h02) begin
            v.pcw = 1; v.pcsel = 2'b10; exp_q.push_back(v); return;
        end
        if (!is_legal(op, fn)) begin
            v.ill = 1; exp_q.push_back(v); return;
        end
        exp_q.push_back(v);
        lw = (op == 6'h23);
        sw = (op == 6'h2b);
        ex = '0; ex.st = 3'd3;
        if (op == 6'h00) begin
            ex.regdst = 2'b01; ex.aluctrl = (fn == 6'h21) ? 5'd1 : 5'd3;
        end else if (op == 6'h0d) begin
            ex.alusrc = 1; ex.aluctrl = 5'd6;
        end else if (op == 6'h04) begin
            ex.aluctrl = 5'd11; ex.pcw = z; ex.pcsel = 2'b01;
            exp_q.push_back(ex); return;
        end else begin
            ex.alusrc = 1; ex.extop = 1; ex.aluctrl = 5'd1;
        end
        exp_q.push_back(ex);
        if (lw || sw) begin
            tmo = (w > 15);
            n   = tmo ? 16 : w + 1;
            for (int k = 1; k <= n; k++) begin
                v = '0; v.st = 3'd4; v.mrd = lw; v.mwr = sw;
                v.berr = tmo && (k == n);
                exp_q.push_back(v);
            end
            if (sw || tmo) return;
        end
        v = ex; v.st = 3'd5; v.rwr = 1; v.dtr = lw ? 2'b01 : 2'b00;
        exp_q.push_back(v);
    endtask

    // Run one instruction from its IF cycle; optionally pull reset low at cycle rst_c
    task automatic run(input int id, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int w, input int rst_c);
        build(op, fn, z, w);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            opcode    = op;
            func      = fn;
            zero      = z;
            mem_ready = (c >= 3) ? (c - 3 >= w) : 1'($urandom);
            #1;
            chk($sformatf("i%0d op%h c%0d", id, op, c), 32'(dut_v), 32'(exp_q[c]));
            if (c == rst_c) begin
                #2 rstn = 1'b0;
                #1 chk($sformatf("i%0d rst_async", id), 32'(dut_v), 32'd0);
                @(negedge clk);
                chk($sformatf("i%0d rst_hold", id), 32'(dut_v), 32'd0);
                rstn = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int         k, w, rc;
        rstn = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        #13;
        chk("reset", 32'(dut_v), 32'd0);
        @(negedge clk);
        chk("reset_hold", 32'(dut_v), 32'd0);
        rstn = 1'b1;

        run(0, 6'h00, 6'h21, 1'b0, 0, -1);
        run(1, 6'h04, 6'h00, 1'b1, 0, -1);
        run(2, 6'h04, 6'h00, 1'b0, 0, -1);
        run(3, 6'h23, 6'h00, 1'b0, 3, -1);
        run(4, 6'h2b, 6'h00, 1'b0, 999, -1);
        run(5, 6'h3f, 6'h00, 1'b0, 0, -1);
        run(6, 6'h02, 6'h00, 1'b0, 0, -1);
        run(7, 6'h23, 6'h00, 1'b0, 15, -1);
        run(8, 6'h23, 6'h00, 1'b0, 16, -1);
        run(9, 6'h0d, 6'h00, 1'b0, 0, -1);
        run(10, 6'h00, 6'h23, 1'b0, 0, -1);
        run(11, 6'h23, 6'h00, 1'b0, 10, 4);
        run(12, 6'h2b, 6'h00, 1'b0, 0, -1);

        for (int i = 13; i < 250; i++) begin
            k  = $urandom_range(0, 8);
            fn = 6'($urandom);
            case (k)
                0: begin op = 6'h00; fn = 6'h21; end
                1: begin op = 6'h00; fn = 6'h23; end
                2: op = 6'h0d;
                3: op = 6'h04;
                4: op = 6'h23;
                5: op = 6'h2b;
                6: op = 6'h02;
                7: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            rc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            run(i, op, fn, 1'($urandom), w, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
